// File: rtl/aes128_ctrl_pkg.sv
// Shared types and constants for the AES-128 streaming sequencer.
package aes128_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARM,
      ST_WAIT_IN,
      ST_ISSUE,
      ST_WAIT_CORE,
      ST_OUT
   } state_e;

   localparam logic [3:0] MODE_ECB = 4'd0;
   localparam logic [3:0] MODE_CBC = 4'd1;
   localparam logic [3:0] MODE_CFB = 4'd2;
   localparam logic [3:0] MODE_OFB = 4'd3;
   localparam logic [3:0] MODE_CTR = 4'd4;

   localparam logic [3:0] SEG_1   = 4'd0;
   localparam logic [3:0] SEG_2   = 4'd1;
   localparam logic [3:0] SEG_4   = 4'd2;
   localparam logic [3:0] SEG_8   = 4'd3;
   localparam logic [3:0] SEG_16  = 4'd4;
   localparam logic [3:0] SEG_32  = 4'd5;
   localparam logic [3:0] SEG_64  = 4'd6;
   localparam logic [3:0] SEG_128 = 4'd7;

   // CFB keeps only the top 2^seg result bits; every other mode passes the
   // whole block. seg is validated to 0..7 before it ever reaches here.
   function automatic logic [127:0] seg_mask(input logic [3:0] mode, input logic [3:0] seg);
      logic [127:0] ones;
      logic [8:0]   nbits;
      ones  = '1;
      nbits = 9'd1 << seg;
      if (mode == MODE_CFB) seg_mask = ~(ones >> nbits);
      else                  seg_mask = ones;
   endfunction

endpackage

// File: rtl/aes128_stream_ctrl.sv
// Streaming sequencer in front of the aes128 core: latches a message config,
// issues one core operation per input block, returns masked results and
// aborts the message if the core never signals completion.
module aes128_stream_ctrl
   import aes128_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cfg_start,
   input  logic [127:0] cfg_key,
   input  logic [127:0] cfg_iv,
   input  logic [3:0]   cfg_mode,
   input  logic [3:0]   cfg_seg,
   input  logic         cfg_decipher,
   input  logic         s_valid,
   output logic         s_ready,
   input  logic [127:0] s_data,
   input  logic         s_last,
   output logic         m_valid,
   input  logic         m_ready,
   output logic [127:0] m_data,
   output logic         m_last,
   output logic         core_cipher_en,
   output logic         core_decipher_en,
   output logic         core_chain_en,
   output logic [127:0] core_data_in,
   output logic [127:0] core_key,
   output logic [127:0] core_init_vector,
   output logic [3:0]   core_mode,
   output logic [15:0]  core_segment_len,
   input  logic [127:0] core_data_out,
   input  logic         core_ready,
   output logic         busy,
   output logic         err_cfg,
   output logic         err_timeout
);

   localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT - 1);

   state_e       state_q, state_d;
   logic [127:0] key_q, key_d;
   logic [127:0] iv_q, iv_d;
   logic [3:0]   mode_q, mode_d;
   logic [3:0]   seg_q, seg_d;
   logic         dec_q, dec_d;
   logic [127:0] data_q, data_d;
   logic         last_q, last_d;
   logic [127:0] mdata_q, mdata_d;
   logic         core_ready_q, core_ready_d;
   logic [7:0]   wdog_q, wdog_d;
   logic         err_cfg_q, err_cfg_d;
   logic         err_to_q, err_to_d;

   // State, latched config, block/result registers and watchdog.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         key_q        <= '0;
         iv_q         <= '0;
         mode_q       <= '0;
         seg_q        <= '0;
         dec_q        <= 1'b0;
         data_q       <= '0;
         last_q       <= 1'b0;
         mdata_q      <= '0;
         core_ready_q <= 1'b0;
         wdog_q       <= '0;
         err_cfg_q    <= 1'b0;
         err_to_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         key_q        <= key_d;
         iv_q         <= iv_d;
         mode_q       <= mode_d;
         seg_q        <= seg_d;
         dec_q        <= dec_d;
         data_q       <= data_d;
         last_q       <= last_d;
         mdata_q      <= mdata_d;
         core_ready_q <= core_ready_d;
         wdog_q       <= wdog_d;
         err_cfg_q    <= err_cfg_d;
         err_to_q     <= err_to_d;
      end
   end

   // Next-state logic and state-decoded handshake/core-control outputs.
   always_comb begin
      state_d          = state_q;
      key_d            = key_q;
      iv_d             = iv_q;
      mode_d           = mode_q;
      seg_d            = seg_q;
      dec_d            = dec_q;
      data_d           = data_q;
      last_d           = last_q;
      mdata_d          = mdata_q;
      core_ready_d     = core_ready;
      wdog_d           = wdog_q;
      err_cfg_d        = err_cfg_q;
      err_to_d         = err_to_q;
      s_ready          = 1'b0;
      m_valid          = 1'b0;
      core_cipher_en   = 1'b0;
      core_decipher_en = 1'b0;
      core_chain_en    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cfg_start) begin
               if (cfg_mode <= MODE_CTR && cfg_seg <= SEG_128) begin
                  key_d     = cfg_key;
                  iv_d      = cfg_iv;
                  mode_d    = cfg_mode;
                  seg_d     = cfg_seg;
                  dec_d     = cfg_decipher;
                  err_cfg_d = 1'b0;
                  err_to_d  = 1'b0;
                  state_d   = ST_ARM;
               end else begin
                  err_cfg_d = 1'b1;
               end
            end
         end
         // chain_en low for this one cycle restarts the core chain from the IV
         ST_ARM: state_d = ST_WAIT_IN;
         ST_WAIT_IN: begin
            s_ready       = 1'b1;
            core_chain_en = 1'b1;
            if (s_valid) begin
               data_d  = s_data;
               last_d  = s_last;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            core_chain_en    = 1'b1;
            core_cipher_en   = !dec_q;
            core_decipher_en = dec_q;
            wdog_d           = '0;
            state_d          = ST_WAIT_CORE;
         end
         ST_WAIT_CORE: begin
            core_chain_en = 1'b1;
            // only a fresh rise counts; a level left over from before is ignored
            if (core_ready && !core_ready_q) begin
               mdata_d = core_data_out & seg_mask(mode_q, seg_q);
               state_d = ST_OUT;
            end else if (wdog_q == WD_LIMIT) begin
               err_to_d = 1'b1;
               state_d  = ST_IDLE;
            end else if (wdog_q != 8'hff) begin
               wdog_d = wdog_q + 8'd1;
            end
         end
         ST_OUT: begin
            core_chain_en = 1'b1;
            m_valid       = 1'b1;
            if (m_ready) state_d = last_q ? ST_IDLE : ST_WAIT_IN;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign busy             = (state_q != ST_IDLE);
   assign m_data           = mdata_q;
   assign m_last           = last_q;
   assign core_data_in     = data_q;
   assign core_key         = key_q;
   assign core_init_vector = iv_q;
   assign core_mode        = mode_q;
   assign core_segment_len = {12'b0, seg_q};
   assign err_cfg          = err_cfg_q;
   assign err_timeout      = err_to_q;

endmodule

// File: tb/tb_aes128_stream_ctrl.sv
// Bench for aes128_stream_ctrl: a behavioural core returns queued responses,
// a scoreboard holds expected masked results and expected core operands.
module tb_aes128_stream_ctrl;

   typedef struct packed {
      logic [127:0] key;
      logic [127:0] iv;
      logic [127:0] data;
      logic [3:0]   mode;
      logic [3:0]   seg;
      logic         dec;
   } op_t;

   typedef struct packed {
      logic [127:0] data;
      logic         last;
   } out_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         cfg_start;
   logic [127:0] cfg_key, cfg_iv;
   logic [3:0]   cfg_mode, cfg_seg;
   logic         cfg_decipher;
   logic         s_valid, s_ready, s_last;
   logic [127:0] s_data;
   logic         m_valid, m_ready, m_last;
   logic [127:0] m_data;
   logic         core_cipher_en, core_decipher_en, core_chain_en;
   logic [127:0] core_data_in, core_key, core_init_vector;
   logic [3:0]   core_mode;
   logic [15:0]  core_segment_len;
   logic [127:0] core_data_out = '0;
   logic         core_ready = 1'b1;
   logic         busy, err_cfg, err_timeout;

   int n_chk = 0;
   int n_err = 0;
   int en_cnt = 0;

   op_t  op_q[$];
   out_t sb[$];
   logic [127:0] resp_q[$];

   logic [127:0] cur_key, cur_iv;
   logic [3:0]   cur_mode, cur_seg;
   logic         cur_dec;
   int           core_lat = 3;
   logic         core_hang = 1'b0;
   int           lat_cnt = 0;
   logic         pending = 1'b0;

   localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] IV  = 128'h000102030405060708090a0b0c0d0e0f;

   aes128_stream_ctrl #(.TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_key(cfg_key), .cfg_iv(cfg_iv),
      .cfg_mode(cfg_mode), .cfg_seg(cfg_seg), .cfg_decipher(cfg_decipher),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .core_cipher_en(core_cipher_en), .core_decipher_en(core_decipher_en),
      .core_chain_en(core_chain_en), .core_data_in(core_data_in), .core_key(core_key),
      .core_init_vector(core_init_vector), .core_mode(core_mode),
      .core_segment_len(core_segment_len), .core_data_out(core_data_out),
      .core_ready(core_ready), .busy(busy), .err_cfg(err_cfg), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got=%h want=%h", tag, act, exp);
      end
   endtask

   function automatic logic [127:0] tb_mask(input logic [3:0] mode, input logic [3:0] seg);
      int keep;
      keep = (mode == 4'd2) ? (1 << seg) : 128;
      for (int i = 0; i < 128; i++) tb_mask[i] = (i >= 128 - keep);
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // behavioural core: drops ready on an enable, raises it core_lat cycles later
   always @(posedge clk) begin
      if (core_cipher_en || core_decipher_en) begin
         core_ready <= 1'b0;
         lat_cnt    <= core_lat;
         pending    <= !core_hang;
      end else if (pending) begin
         if (lat_cnt <= 1) begin
            core_ready    <= 1'b1;
            core_data_out <= (resp_q.size() > 0) ? resp_q.pop_front() : '0;
            pending       <= 1'b0;
         end else begin
            lat_cnt <= lat_cnt - 1;
         end
      end
   end

   // core operand monitor
   op_t mon_op;
   always @(negedge clk) begin
      if (core_cipher_en || core_decipher_en) begin
         en_cnt <= en_cnt + 1;
         chk("en_onehot", core_cipher_en & core_decipher_en, 0);
         chk("issue_chain", core_chain_en, 1);
         if (op_q.size() == 0) chk("op_unexp", op_q.size(), 1);
         else begin
            mon_op = op_q.pop_front();
            chk("core_key", core_key, mon_op.key);
            chk("core_iv", core_init_vector, mon_op.iv);
            chk("core_din", core_data_in, mon_op.data);
            chk("core_mode", core_mode, mon_op.mode);
            chk("core_seglen", core_segment_len, {12'b0, mon_op.seg});
            chk("core_dec", core_decipher_en, mon_op.dec);
         end
      end
   end

   // result monitor
   out_t mon_out;
   always @(negedge clk) begin
      if (m_valid && m_ready) begin
         if (sb.size() == 0) chk("out_unexp", m_valid, 0);
         else begin
            mon_out = sb.pop_front();
            chk("m_data", m_data, mon_out.data);
            chk("m_last", m_last, mon_out.last);
         end
      end
   end

   task automatic check_reset(input string t);
      chk({t, "_s_ready"}, s_ready, 0);
      chk({t, "_m_valid"}, m_valid, 0);
      chk({t, "_m_last"}, m_last, 0);
      chk({t, "_cen"}, core_cipher_en, 0);
      chk({t, "_den"}, core_decipher_en, 0);
      chk({t, "_chain"}, core_chain_en, 0);
      chk({t, "_busy"}, busy, 0);
      chk({t, "_err_cfg"}, err_cfg, 0);
      chk({t, "_err_to"}, err_timeout, 0);
      chk({t, "_m_data"}, m_data, 0);
      chk({t, "_din"}, core_data_in, 0);
      chk({t, "_key"}, core_key, 0);
      chk({t, "_iv"}, core_init_vector, 0);
      chk({t, "_mode"}, core_mode, 0);
      chk({t, "_seglen"}, core_segment_len, 0);
   endtask

   task automatic start_msg(input logic [127:0] k, input logic [127:0] v, input logic [3:0] md,
                            input logic [3:0] sg, input logic dc, input bit good);
      @(posedge clk); #1;
      cfg_key = k; cfg_iv = v; cfg_mode = md; cfg_seg = sg; cfg_decipher = dc; cfg_start = 1'b1;
      @(posedge clk); #1;
      cfg_start = 1'b0;
      @(negedge clk);
      if (good) begin
         chk("arm_chain", core_chain_en, 0);
         chk("arm_s_ready", s_ready, 0);
         chk("arm_busy", busy, 1);
         chk("arm_err_to", err_timeout, 0);
         chk("arm_err_cfg", err_cfg, 0);
         @(negedge clk);
         chk("wi_s_ready", s_ready, 1);
         chk("wi_chain", core_chain_en, 1);
         cur_key = k; cur_iv = v; cur_mode = md; cur_seg = sg; cur_dec = dc;
      end else begin
         chk("bad_err_cfg", err_cfg, 1);
         chk("bad_busy", busy, 0);
      end
   endtask

   // returns one cycle after the handshake edge, i.e. in the ISSUE cycle
   task automatic send_block(input logic [127:0] d, input logic last, input logic [127:0] resp,
                             input bit expect_out);
      op_t  o;
      out_t e;
      bit   ok;
      o.key = cur_key; o.iv = cur_iv; o.data = d; o.mode = cur_mode; o.seg = cur_seg; o.dec = cur_dec;
      op_q.push_back(o);
      if (expect_out) begin
         resp_q.push_back(resp);
         e.data = resp & tb_mask(cur_mode, cur_seg);
         e.last = last;
         sb.push_back(e);
      end
      ok = 1'b0;
      @(posedge clk); #1;
      s_valid = 1'b1; s_data = d; s_last = last;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (s_ready) begin ok = 1'b1; break; end
      end
      if (!ok) chk("s_hs_wait", s_ready, 1);
      @(posedge clk); #1;
      s_valid = 1'b0; s_data = '0; s_last = 1'b0;
   endtask

   task automatic wait_done(input string t);
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (!busy && sb.size() == 0) break;
      end
      chk({t, "_busy"}, busy, 0);
      chk({t, "_sb"}, sb.size(), 0);
   endtask

   logic [127:0] r, held;
   int           e0;
   bit           seen;

   initial begin
      rst = 1'b1; cfg_start = 1'b0; cfg_key = '0; cfg_iv = '0; cfg_mode = '0; cfg_seg = '0;
      cfg_decipher = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset("rst");
      @(posedge clk); #1;
      rst = 1'b0;

      // 128-CFB cipher, known-answer vectors
      start_msg(KEY, IV, 4'd2, 4'd7, 1'b0, 1);
      send_block(128'h6bc1bee22e409f96e93d7e117393172a, 1'b0, 128'h3b3fd92eb72dad20333449f8e83cfb4a, 1);
      send_block(128'hae2d8a571e03ac9c9eb76fac45af8e51, 1'b1, 128'hc8a64537a0b3a93fcde3cdad9f1ce58b, 1);
      wait_done("cfb128");

      // 8-CFB: lower 120 bits of the core output carry junk that must be masked
      start_msg(KEY, IV, 4'd2, 4'd3, 1'b0, 1);
      r = rnd128(); send_block({8'h6b, 120'b0}, 1'b0, {8'h3b, r[119:0]}, 1);
      r = rnd128(); send_block({8'hc1, 120'b0}, 1'b0, {8'h79, r[119:0]}, 1);
      r = rnd128(); send_block({8'hbe, 120'b0}, 1'b0, {8'h42, r[119:0]}, 1);
      r = rnd128(); send_block({8'he2, 120'b0}, 1'b1, {8'h4c, r[119:0]}, 1);
      wait_done("cfb8");

      // 1-CFB; a cfg_start mid-message (bad seg, other key) must be ignored
      start_msg(KEY, IV, 4'd2, 4'd0, 1'b0, 1);
      @(posedge clk); #1;
      cfg_key = ~KEY; cfg_mode = 4'd1; cfg_seg = 4'd9; cfg_start = 1'b1;
      @(posedge clk); #1;
      cfg_start = 1'b0;
      @(negedge clk);
      chk("ign_err_cfg", err_cfg, 0);
      chk("ign_key", core_key, KEY);
      chk("ign_mode", core_mode, 2);
      r = rnd128(); send_block(128'h0, 1'b0, {1'b0, r[126:0]}, 1);
      r = rnd128(); send_block({1'b1, 127'b0}, 1'b1, {1'b1, r[126:0]}, 1);
      wait_done("cfb1");

      // new message (ARM shows chain_en low once), ECB decipher with backpressure
      m_ready = 1'b0;
      start_msg(~KEY, ~IV, 4'd0, 4'd5, 1'b1, 1);
      r = rnd128(); send_block(128'h0123456789abcdef0011223344556677, 1'b1, r, 1);
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (m_valid) begin seen = 1'b1; break; end
      end
      if (!seen) chk("bp_wait", m_valid, 1);
      held = m_data;
      e0 = en_cnt;
      for (int k = 0; k < 5; k++) begin
         chk("bp_valid", m_valid, 1);
         chk("bp_data", m_data, held);
         chk("bp_s_ready", s_ready, 0);
         chk("bp_en", en_cnt, e0);
         @(posedge clk); #1;
      end
      m_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("bp_after", m_valid, 0);
      wait_done("bp");

      // watchdog: core never completes
      core_hang = 1'b1;
      start_msg(KEY, IV, 4'd4, 4'd0, 1'b0, 1);
      send_block(128'hfeedface, 1'b1, '0, 0);
      for (int k = 1; k <= 16; k++) begin
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("to_pre_err", err_timeout, 0);
      chk("to_pre_busy", busy, 1);
      @(posedge clk);
      @(negedge clk);
      chk("to_err", err_timeout, 1);
      chk("to_busy", busy, 0);
      chk("to_chain", core_chain_en, 0);
      chk("to_m_valid", m_valid, 0);
      core_hang = 1'b0;
      start_msg(KEY, IV, 4'd3, 4'd0, 1'b0, 1);
      r = rnd128(); send_block(128'h55, 1'b1, r, 1);
      wait_done("after_to");

      // bad configs
      start_msg(KEY, IV, 4'd2, 4'd9, 1'b0, 0);
      start_msg(KEY, IV, 4'd5, 4'd0, 1'b0, 0);

      // reset while waiting on the core; its late ready edge must be ignored
      core_lat = 8;
      start_msg(KEY, IV, 4'd1, 4'd0, 1'b0, 1);
      send_block(128'h1234, 1'b0, '0, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_reset("wc_rst");
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (12) @(posedge clk);
      @(negedge clk);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_m_valid", m_valid, 0);
      chk("post_rst_ready", core_ready, 1);

      chk("end_sb", sb.size(), 0);
      chk("end_op", op_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout got=running want=finished");
      $fatal(1, "simulation time limit");
   end

endmodule
